// File: rtl/vmicro16_uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helpers.
package vmicro16_uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  // Whole system clocks per serial bit (truncating division).
  function automatic int unsigned uart_clks_per_bit(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Clocks from a start-bit falling edge to the middle of the start bit.
  function automatic int unsigned uart_half_bit(input int unsigned clk_hz,
                                                input int unsigned baud);
    return uart_clks_per_bit(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/vmicro16_uart_rx_fifo.sv
// Show-ahead byte FIFO for the UART receiver. Pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module vmicro16_uart_rx_fifo
  import vmicro16_uart_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_full,
  output logic       o_overflow
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0] r_wr_ptr;
  logic [AddrW:0] r_rd_ptr;
  logic [7:0]     r_mem [Depth];

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AddrW] != r_rd_ptr[AddrW]) &&
                   (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]);

  // A pop on an empty FIFO is ignored; a pop frees the slot a same-cycle push needs.
  assign w_do_pop   = i_pop & ~w_empty;
  assign w_do_push  = i_push & (~w_full | w_do_pop);
  assign o_overflow = i_push & w_full & ~w_do_pop;

  assign o_valid = ~w_empty;
  assign o_full  = w_full;
  // Head is forced to zero while empty so the output has a defined reset value.
  assign o_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr[AddrW-1:0]];

  // Pointer state, wrapping modulo 2*Depth.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are only observable through the pointers.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AddrW-1:0]] <= i_data;
  end

endmodule

// File: rtl/vmicro16_uart_rx.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling FSM and a receive FIFO.
module vmicro16_uart_rx
  import vmicro16_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err,
  output logic       busy
);

  localparam int unsigned ClksPerBit = uart_clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned HalfBit    = uart_half_bit(CLK_HZ, BAUD);
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntBitLast  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntHalfLast = CntW'(HalfBit - 1);

  logic [1:0]      r_sync;
  logic            r_rxd_q;
  uart_state_e     r_state;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_frame_err;
  logic            r_overrun;

  uart_state_e     w_state_d;
  logic [CntW-1:0] w_cnt_d;
  logic [2:0]      w_idx_d;
  logic [7:0]      w_shift_d;
  logic            w_frame_err_d;
  logic            w_push;
  logic            w_overflow;
  logic            w_fifo_full;
  logic            w_rxd_s;

  assign w_rxd_s = r_sync[1];

  // Two-flop synchronizer plus one history flop for start-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync  <= 2'b11;
      r_rxd_q <= 1'b1;
    end else begin
      r_sync  <= {r_sync[0], rxd};
      r_rxd_q <= w_rxd_s;
    end
  end

  // Receiver FSM and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_idx       <= w_idx_d;
      r_shift     <= w_shift_d;
      r_frame_err <= w_frame_err_d;
    end
  end

  // Next-state logic: sample mid start bit, then every full bit period after it.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_idx_d       = r_idx;
    w_shift_d     = r_shift;
    w_frame_err_d = 1'b0;
    w_push        = 1'b0;
    case (r_state)
      StIdle: begin
        // Edge, not level: a line stuck low must not start frame after frame.
        if (r_rxd_q && !w_rxd_s) begin
          w_state_d = StStart;
          w_cnt_d   = '0;
        end
      end
      StStart: begin
        if (r_cnt == CntHalfLast) begin
          if (!w_rxd_s) begin
            w_state_d = StData;
            w_cnt_d   = '0;
            w_idx_d   = '0;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StData: begin
        if (r_cnt == CntBitLast) begin
          w_shift_d[r_idx] = w_rxd_s;
          w_cnt_d          = '0;
          w_idx_d          = r_idx + 1'b1;
          if (r_idx == 3'd7) w_state_d = StStop;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StStop: begin
        if (r_cnt == CntBitLast) begin
          w_cnt_d   = '0;
          w_state_d = StIdle;
          if (w_rxd_s) w_push        = 1'b1;
          else         w_frame_err_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Sticky overrun; a new drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (w_overflow) begin
      r_overrun <= 1'b1;
    end else if (clr_err) begin
      r_overrun <= 1'b0;
    end
  end

  vmicro16_uart_rx_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_push     (w_push),
    .i_data     (r_shift),
    .i_pop      (rx_ready),
    .o_data     (rx_data),
    .o_valid    (rx_valid),
    .o_full     (w_fifo_full),
    .o_overflow (w_overflow)
  );

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_vmicro16_uart_rx.sv
// Self-checking bench for vmicro16_uart_rx at 16 clocks per bit, 4-entry FIFO.
`timescale 1ns/1ps
module tb_vmicro16_uart_rx;

  localparam int unsigned ClkHz = 1600;
  localparam int unsigned Baud  = 100;
  localparam int unsigned Depth = 4;
  localparam int Cpb = 16;
  // Frame-relative iteration whose values meet the stop-sample edge:
  // 2 synchronizer flops, 1 edge-detect cycle, half a bit in START minus one,
  // 8 data bits and a full stop-bit count.
  localparam int StopIter = 2 + Cpb / 2 + 9 * Cpb;
  localparam int PushLatency = StopIter + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Monitor state, written only by the negedge monitor.
  int         cyc = 0;
  logic [7:0] got_q[$];
  int         ferr_cnt = 0;
  int         busy_cnt = 0;
  int         last_rise = -1;
  logic       prev_valid = 1'b0;

  vmicro16_uart_rx #(
    .CLK_HZ     (ClkHz),
    .BAUD       (Baud),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (rx_valid && !prev_valid) last_rise <= cyc;
    prev_valid <= rx_valid;
  end

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drive one 8N1 frame; optionally strobe rx_ready or clr_err at the stop sample.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input bit pop_at_stop, input bit clr_at_stop, output int t0);
    logic [9:0] bits;
    int bi;
    bits = {stop_bit, b, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10 * Cpb; i++) begin
      bi = i / Cpb;
      rxd = bits[bi[3:0]];
      if (pop_at_stop) rx_ready = (i == StopIter);
      if (clr_at_stop) clr_err = (i == StopIter);
      @(posedge clk); #1;
    end
    if (pop_at_stop) rx_ready = 1'b0;
    if (clr_at_stop) clr_err = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b1;
    idle(5);
  endtask

  task automatic test_basic();
    logic [7:0] sent[$];
    int base, bf, t0;
    sent = '{8'h55, 8'hA3};
    repeat (4) sent.push_back(8'($urandom));
    rx_ready = 1'b1;
    base = got_q.size();
    bf = ferr_cnt;
    foreach (sent[k]) begin
      send_frame(sent[k], 1'b1, 1'b0, 1'b0, t0);
      if (k == 0) begin
        checks++; if (last_rise !== t0 + PushLatency) begin errors++; $display("FAIL basic_push_latency: got %0d want %0d", last_rise - t0, PushLatency); end
      end
      idle(2 + k);
    end
    idle(10);
    checks++; if (got_q.size() - base !== sent.size()) begin errors++; $display("FAIL basic_count: got %0d want %0d", got_q.size() - base, sent.size()); end
    foreach (sent[k]) begin
      checks++; if (got_q[base + k] !== sent[k]) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", k, got_q[base + k], sent[k]); end
    end
    checks++; if (ferr_cnt - bf !== 0) begin errors++; $display("FAIL basic_frame_err: got %0d want 0", ferr_cnt - bf); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_glitch();
    int base, bb;
    base = got_q.size();
    bb = busy_cnt;
    rxd = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    idle(40);
    checks++; if (busy_cnt - bb < 1 || busy_cnt - bb > 11) begin errors++; $display("FAIL glitch_busy_len: got %0d want 1..11", busy_cnt - bb); end
    checks++; if (got_q.size() - base !== 0) begin errors++; $display("FAIL glitch_no_pop: got %0d want 0", got_q.size() - base); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_rx_valid: got %b want 0", rx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_frame_err();
    int base, bf, bb, t0;
    rx_ready = 1'b1;
    base = got_q.size();
    bf = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, t0);
    bb = busy_cnt;
    rxd = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    checks++; if (ferr_cnt - bf !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt - bf); end
    checks++; if (busy_cnt - bb !== 0) begin errors++; $display("FAIL ferr_no_retrigger: got %0d busy cycles want 0", busy_cnt - bb); end
    checks++; if (got_q.size() - base !== 0) begin errors++; $display("FAIL ferr_no_push: got %0d want 0", got_q.size() - base); end
    idle(20);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, t0);
    idle(10);
    checks++; if (got_q.size() - base !== 1) begin errors++; $display("FAIL ferr_recover_count: got %0d want 1", got_q.size() - base); end
    checks++; if (got_q[base] !== 8'h5A) begin errors++; $display("FAIL ferr_recover_byte: got %h want 5a", got_q[base]); end
  endtask

  task automatic test_overrun();
    logic [7:0] mq[$];
    logic ovf;
    int base, t0;
    rx_ready = 1'b0;
    ovf = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      // Byte 5 arrives with clr_err at the same cycle as its drop.
      send_frame(8'(v), 1'b1, 1'b0, (v == 5), t0);
      if (mq.size() < Depth) mq.push_back(8'(v));
      else ovf = 1'b1;
      idle(4);
      if (v == 4) begin
        checks++; if (overrun !== ovf) begin errors++; $display("FAIL ovr_before_full: got %b want %b", overrun, ovf); end
      end
    end
    checks++; if (overrun !== ovf) begin errors++; $display("FAIL ovr_set_wins: got %b want %b", overrun, ovf); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_rx_valid: got %b want 1", rx_valid); end
    idle(7);
    checks++; if (rx_data !== mq[0]) begin errors++; $display("FAIL ovr_head_stable: got %h want %h", rx_data, mq[0]); end
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    base = got_q.size();
    rx_ready = 1'b1;
    idle(8);
    rx_ready = 1'b0;
    checks++; if (got_q.size() - base !== mq.size()) begin errors++; $display("FAIL ovr_drain_count: got %0d want %0d", got_q.size() - base, mq.size()); end
    foreach (mq[k]) begin
      checks++; if (got_q[base + k] !== mq[k]) begin errors++; $display("FAIL ovr_drain%0d: got %h want %h", k, got_q[base + k], mq[k]); end
    end
  endtask

  task automatic test_collide();
    logic [7:0] mq[$];
    int base, t0;
    rx_ready = 1'b0;
    base = got_q.size();
    for (int v = 1; v <= 5; v++) begin
      if (v == 5) begin
        // Pop and push land on the same edge while full: pop first, then room for the push.
        mq.push_back(8'(v));
        send_frame(8'(v), 1'b1, 1'b1, 1'b0, t0);
      end else begin
        mq.push_back(8'(v));
        send_frame(8'(v), 1'b1, 1'b0, 1'b0, t0);
      end
      idle(4);
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL collide_overrun: got %b want 0", overrun); end
    rx_ready = 1'b1;
    idle(8);
    rx_ready = 1'b0;
    checks++; if (got_q.size() - base !== mq.size()) begin errors++; $display("FAIL collide_count: got %0d want %0d", got_q.size() - base, mq.size()); end
    foreach (mq[k]) begin
      checks++; if (got_q[base + k] !== mq[k]) begin errors++; $display("FAIL collide_order%0d: got %h want %h", k, got_q[base + k], mq[k]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    int base, bb, bi, t0;
    rx_ready = 1'b0;
    send_frame(8'h42, 1'b1, 1'b0, 1'b0, t0);
    idle(4);
    checks++; if (rx_data !== 8'h42 || rx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %h/%b want 42/1", rx_data, rx_valid); end
    bits = {1'b1, 8'hFF, 1'b0};
    // Stop partway through data bit 3 of 0xFF.
    for (int i = 0; i < 70; i++) begin
      bi = i / Cpb;
      rxd = bits[bi[3:0]];
      @(posedge clk); #1;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre: got %b want 1", busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rx_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data: got %h want 00", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rstmid_errs: got %b/%b want 0/0", frame_err, overrun); end
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    base = got_q.size();
    bb = busy_cnt;
    idle(40);
    checks++; if (busy_cnt - bb !== 0 || rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got busy=%0d valid=%b want 0/0", busy_cnt - bb, rx_valid); end
    rx_ready = 1'b1;
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, t0);
    idle(10);
    checks++; if (got_q.size() - base !== 1) begin errors++; $display("FAIL rstmid_after_count: got %0d want 1", got_q.size() - base); end
    checks++; if (got_q[base] !== 8'h81) begin errors++; $display("FAIL rstmid_after_byte: got %h want 81", got_q[base]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_collide();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vmicro16_uart_rx.md
VMICRO16_UART_RX -- requirements
Module: vmicro16_uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning the system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the receive FIFO entries; it is a power of 2 and at least 2.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, an asynchronous active-low reset (0 = reset asserted).
REQ-006 SHALL have port rxd, input, 1 bit, the asynchronous serial line; it idles high and carries 8N1, LSB first.
REQ-007 SHALL have port rx_data, output, 8 bits, the byte at the FIFO head (show-ahead).
REQ-008 SHALL have port rx_valid, output, 1 bit, high while the FIFO is non-empty.
REQ-009 SHALL have port rx_ready, input, 1 bit; rx_valid and rx_ready both high pops one byte.
REQ-010 SHALL have port frame_err, output, 1 bit, a one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun, output, 1 bit, sticky; set when a byte is dropped because the FIFO is full.
REQ-012 SHALL have port clr_err, input, 1 bit, a synchronous clear of overrun.
REQ-013 SHALL have port busy, output, 1 bit, high whenever the FSM is not IDLE.

Function
REQ-014 SHALL compute CLKS_PER_BIT = CLK_HZ/BAUD (integer division); HALF_BIT = CLKS_PER_BIT/2; the bit counter width is clog2(CLKS_PER_BIT).
REQ-015 SHALL pass rxd through a 2-flop synchronizer (reset value 1) to give rxd_s, plus one history flop rxd_q (reset value 1).
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-017 In IDLE, SHALL enter START with the counter cleared when rxd_q=1 and rxd_s=0 (falling edge only); a line held low never re-triggers.
REQ-018 In START, SHALL sample rxd_s when the counter reaches HALF_BIT-1: if 0, go to DATA with the counter and bit index cleared; if 1, treat it as a glitch and return to IDLE with no output.
REQ-019 In DATA, SHALL sample rxd_s each time the counter reaches CLKS_PER_BIT-1 (mid-bit), shift it into bit[index] (LSB first) and clear the counter; after index 7, go to STOP.
REQ-020 In STOP, at counter CLKS_PER_BIT-1: if rxd_s=1, push the byte and go to IDLE; if rxd_s=0, pulse frame_err for 1 cycle, discard the byte and go to IDLE.
REQ-021 FIFO push latency: the byte SHALL appear on rx_data, with rx_valid high, in the cycle after the stop sample.
REQ-022 Push when full and no pop: the byte SHALL be dropped, overrun set, and FIFO contents unchanged.
REQ-023 Push and pop in the same cycle while full SHALL both succeed with no overrun; while empty, the pop is ignored and the push succeeds.
REQ-024 rx_data SHALL hold stable while rx_valid=1 and rx_ready=0.
REQ-025 If an overrun set and clr_err occur in the same cycle, set SHALL win.
REQ-026 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full and empty are derived from the MSB and the pointer compare.

Reset
REQ-027 On reset=0, SHALL asynchronously force: FSM=IDLE; counter, bit index and shift register=0; FIFO pointers=0; rx_valid=0, rx_data=0, frame_err=0, overrun=0, busy=0; synchronizer and rxd_q=1.
REQ-028 Reset asserted mid-frame SHALL discard the partial byte and FIFO contents; after release, no output results until a new falling edge.
REQ-029 Reset deassertion SHALL be synchronized externally; the block does not add a reset synchronizer.

Structure
REQ-030 A shared header/package vmicro16_uart_pkg SHALL hold the FSM state encodings and the CLKS_PER_BIT/HALF_BIT computation, so a future TX reuses them.
REQ-031 The FIFO SHALL be one sub-module, vmicro16_uart_rx_fifo (push/pop/full/empty, show-ahead); the FSM, synchronizer and counter stay in the top.

Verification (sim with CLK_HZ=1600, BAUD=100, so CLKS_PER_BIT=16)
REQ-032 Scenario: send 0x55, then 0xA3, with rx_ready=1 -> two rx_valid pops, data 0x55 then 0xA3, frame_err=0, overrun=0.
REQ-033 Scenario: an rxd low pulse of 4 clocks -> FSM returns to IDLE, no rx_valid, busy high for no more than 8 clocks plus synchronizer delay.
REQ-034 Scenario: send 0x3C with the stop bit forced 0 and the line held low for 40 clocks -> one frame_err pulse, no push, no new frame until the line rises and falls again.
REQ-035 Scenario: rx_ready=0, send 5 bytes 0x01..0x05 -> FIFO holds 0x01..0x04, overrun=1 after byte 5; clr_err clears it; pops return 0x01..0x04.
REQ-036 Scenario: FIFO full and the 5th stop sample coincides with a pop -> no overrun; order 0x01..0x05 preserved.
REQ-037 Scenario: assert reset during DATA bit 3 of 0xFF -> all outputs at reset values immediately; after release, a following 0x81 is received correctly.
